// File: rtl/alarm_pkg.sv
// Shared encodings and limits for the multi-zone alarm controller.
// No logic; imported by the interface, the controller and the bench.
package alarm_pkg;

  localparam int STATE_W  = 3;
  localparam int ZONE_MAX = 16;

  localparam logic [3:0] ARM_CODE_DEF    = 4'b0011;
  localparam logic [3:0] DISARM_CODE_DEF = 4'b1100;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4,
    ST_SILENCED  = 3'd5
  } state_t;

endpackage

// File: rtl/alarm_zone_ctrl_if.sv
// Keypad/zone inputs and siren/status outputs of the alarm controller.
// master = driver of keypad and sensors, slave = the controller.
interface alarm_zone_ctrl_if #(
  parameter int NUM_ZONES = 8
);
  import alarm_pkg::*;

  logic [3:0]           keypad;
  logic                 keypad_valid;
  logic [NUM_ZONES-1:0] zone_in;
  logic [NUM_ZONES-1:0] zone_bypass;
  logic                 alarm_siren;
  logic                 is_armed;
  logic                 is_exit_delay;
  logic                 is_entry_delay;
  logic                 arm_fail;
  logic [NUM_ZONES-1:0] tripped_zones;
  logic [STATE_W-1:0]   state;

  modport master (
    output keypad, keypad_valid, zone_in, zone_bypass,
    input  alarm_siren, is_armed, is_exit_delay, is_entry_delay, arm_fail, tripped_zones, state
  );

  modport slave (
    input  keypad, keypad_valid, zone_in, zone_bypass,
    output alarm_siren, is_armed, is_exit_delay, is_entry_delay, arm_fail, tripped_zones, state
  );

endinterface

// File: rtl/alarm_delay_timer.sv
// Purpose: saturating down-counter shared by the exit, entry and siren delays.
// Latency: load/decrement visible the cycle after the request; done is combinational on cnt.
// Backpressure: none; load has priority over enable.
module alarm_delay_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Purpose: multi-zone alarm FSM with bypass, instant zones, exit/entry delays and siren timeout.
// Latency: inputs in cycle N are reflected on the registered outputs from cycle N+1.
// Backpressure: none; keypad strobes are sampled once, non-matching codes are dropped.
module alarm_zone_ctrl
  import alarm_pkg::*;
#(
  parameter int                   NUM_ZONES    = 8,
  parameter int                   CNT_W        = 16,
  parameter int                   EXIT_DELAY   = 200,
  parameter int                   ENTRY_DELAY  = 100,
  parameter int                   SIREN_TIME   = 1000,
  parameter logic [NUM_ZONES-1:0] INSTANT_MASK = '0,
  parameter logic [3:0]           ARM_CODE     = ARM_CODE_DEF,
  parameter logic [3:0]           DISARM_CODE  = DISARM_CODE_DEF
) (
  input logic               clk,
  input logic               reset_n,
  alarm_zone_ctrl_if.slave  bus
);

  if (NUM_ZONES < 1 || NUM_ZONES > ZONE_MAX) begin : g_bad_num_zones
    $error("alarm_zone_ctrl: NUM_ZONES out of range");
  end

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME - 1);

  state_t               st;
  state_t               nxt;
  logic [NUM_ZONES-1:0] active;
  logic [NUM_ZONES-1:0] tripped;
  logic                 inst;
  logic                 any;
  logic                 arm;
  logic                 dis;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_en;
  logic                 tmr_done;
  logic                 fail;
  logic                 arm_ok;
  logic                 accum;

  assign active = bus.zone_in & ~bus.zone_bypass;
  assign inst   = |(active & INSTANT_MASK);
  assign any    = |active;
  assign arm    = bus.keypad_valid && (bus.keypad == ARM_CODE);
  assign dis    = bus.keypad_valid && (bus.keypad == DISARM_CODE);

  assign tmr_en = (st == ST_EXIT_DLY) || (st == ST_ENTRY_DLY) || (st == ST_ALARM);
  assign arm_ok = (st == ST_DISARMED) && arm && !any;
  assign accum  = (st == ST_ARMED) || (st == ST_ENTRY_DLY) ||
                  (st == ST_ALARM) || (st == ST_SILENCED);

  // Disarm is tested first in every state so it always beats a zone event.
  always_comb begin
    nxt      = st;
    tmr_load = 1'b0;
    tmr_val  = '0;
    fail     = 1'b0;
    case (st)
      ST_DISARMED: begin
        if (arm && any) begin
          fail = 1'b1;
        end else if (arm) begin
          nxt      = ST_EXIT_DLY;
          tmr_load = 1'b1;
          tmr_val  = EXIT_LD;
        end
      end
      ST_EXIT_DLY: begin
        if (dis)           nxt = ST_DISARMED;
        else if (tmr_done) nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (dis) begin
          nxt = ST_DISARMED;
        end else if (inst) begin
          nxt      = ST_ALARM;
          tmr_load = 1'b1;
          tmr_val  = SIREN_LD;
        end else if (any) begin
          nxt      = ST_ENTRY_DLY;
          tmr_load = 1'b1;
          tmr_val  = ENTRY_LD;
        end
      end
      ST_ENTRY_DLY: begin
        if (dis) begin
          nxt = ST_DISARMED;
        end else if (inst || tmr_done) begin
          nxt      = ST_ALARM;
          tmr_load = 1'b1;
          tmr_val  = SIREN_LD;
        end
      end
      ST_ALARM: begin
        if (dis)           nxt = ST_DISARMED;
        else if (tmr_done) nxt = ST_SILENCED;
      end
      ST_SILENCED: begin
        if (dis) begin
          nxt = ST_DISARMED;
        end else if (|(active & ~tripped)) begin
          nxt      = ST_ALARM;
          tmr_load = 1'b1;
          tmr_val  = SIREN_LD;
        end
      end
      default: nxt = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st                 <= ST_DISARMED;
      tripped            <= '0;
      bus.alarm_siren    <= 1'b0;
      bus.is_armed       <= 1'b0;
      bus.is_exit_delay  <= 1'b0;
      bus.is_entry_delay <= 1'b0;
      bus.arm_fail       <= 1'b0;
    end else begin
      st                 <= nxt;
      bus.alarm_siren    <= (nxt == ST_ALARM);
      bus.is_armed       <= (nxt == ST_ARMED);
      bus.is_exit_delay  <= (nxt == ST_EXIT_DLY);
      bus.is_entry_delay <= (nxt == ST_ENTRY_DLY);
      bus.arm_fail       <= fail;
      if (arm_ok)     tripped <= '0;
      else if (accum) tripped <= tripped | active;
    end
  end

  assign bus.tripped_zones = tripped;
  assign bus.state         = st;

  alarm_delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_en),
    .done     (tmr_done)
  );

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed and random bench for alarm_zone_ctrl (4 zones, short delays, zone 3 instant).
module tb_alarm_zone_ctrl;

  localparam int N     = 4;
  localparam int EXIT  = 4;
  localparam int ENTRY = 5;
  localparam int SIREN = 6;
  localparam logic [3:0] K_ARM  = 4'b0011;
  localparam logic [3:0] K_DIS  = 4'b1100;
  localparam logic [3:0] INST_M = 4'b1000;

  localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4, M_SIL = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alarm_zone_ctrl_if #(.NUM_ZONES(N)) bus ();

  alarm_zone_ctrl #(
    .NUM_ZONES    (N),
    .CNT_W        (16),
    .EXIT_DELAY   (EXIT),
    .ENTRY_DELAY  (ENTRY),
    .SIREN_TIME   (SIREN),
    .INSTANT_MASK (INST_M),
    .ARM_CODE     (K_ARM),
    .DISARM_CODE  (K_DIS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode, cycles spent in the current mode, latched zones, fail pulse.
  int         m_mode = M_DIS;
  int         m_el   = 0;
  logic [3:0] m_trip = '0;
  logic       m_fail = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_DIS;
    m_el   = 0;
    m_trip = '0;
    m_fail = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] kp, input logic kv,
                            input logic [3:0] zin, input logic [3:0] byp);
    logic [3:0] act;
    logic [3:0] old_trip;
    bit a, d, ins, an;
    int nm;
    act      = zin & ~byp;
    a        = kv && (kp == K_ARM);
    d        = kv && (kp == K_DIS);
    ins      = |(act & INST_M);
    an       = |act;
    old_trip = m_trip;
    nm       = m_mode;
    m_fail   = 1'b0;
    if (m_mode >= M_ARMED) m_trip = m_trip | act;
    case (m_mode)
      M_DIS: if (a) begin
        if (an) m_fail = 1'b1;
        else begin nm = M_EXIT; m_trip = '0; end
      end
      M_EXIT:  if (d) nm = M_DIS; else if (m_el + 1 >= EXIT) nm = M_ARMED;
      M_ARMED: if (d) nm = M_DIS; else if (ins) nm = M_ALARM; else if (an) nm = M_ENTRY;
      M_ENTRY: if (d) nm = M_DIS; else if (ins || m_el + 1 >= ENTRY) nm = M_ALARM;
      M_ALARM: if (d) nm = M_DIS; else if (m_el + 1 >= SIREN) nm = M_SIL;
      M_SIL:   if (d) nm = M_DIS; else if (|(act & ~old_trip)) nm = M_ALARM;
      default: nm = M_DIS;
    endcase
    m_el   = (nm != m_mode) ? 0 : m_el + 1;
    m_mode = nm;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".state"}, 32'(bus.state), 32'(m_mode));
    chk({ctx, ".siren"}, 32'(bus.alarm_siren), 32'(m_mode == M_ALARM));
    chk({ctx, ".armed"}, 32'(bus.is_armed), 32'(m_mode == M_ARMED));
    chk({ctx, ".exit"}, 32'(bus.is_exit_delay), 32'(m_mode == M_EXIT));
    chk({ctx, ".entry"}, 32'(bus.is_entry_delay), 32'(m_mode == M_ENTRY));
    chk({ctx, ".fail"}, 32'(bus.arm_fail), 32'(m_fail));
    chk({ctx, ".trip"}, 32'(bus.tripped_zones), 32'(m_trip));
  endtask

  // Drive one cycle of inputs, let the edge pass, advance the model, compare everything.
  task automatic step(input logic [3:0] kp, input logic kv,
                      input logic [3:0] zin, input logic [3:0] byp, input string ctx);
    bus.keypad       = kp;
    bus.keypad_valid = kv;
    bus.zone_in      = zin;
    bus.zone_bypass  = byp;
    @(posedge clk);
    model_step(kp, kv, zin, byp);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input int n, input logic [3:0] zin, input string ctx);
    for (int i = 0; i < n; i++) step(4'h0, 1'b0, zin, 4'h0, ctx);
  endtask

  task automatic arm_now(input string ctx);
    step(K_ARM, 1'b1, 4'h0, 4'h0, ctx);
    idle(EXIT, 4'h0, ctx);
    chk({ctx, ".armed_after_exit"}, 32'(bus.is_armed), 32'd1);
  endtask

  initial begin
    int cnt;
    bus.keypad       = '0;
    bus.keypad_valid = 1'b0;
    bus.zone_in      = '0;
    bus.zone_bypass  = '0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    #4;

    // Arm with zones clear; zone activity during exit delay is ignored.
    step(K_ARM, 1'b1, 4'h0, 4'h0, "arm");
    cnt = 1;
    for (int i = 0; i < 20 && bus.is_exit_delay; i++) begin
      step(4'h0, 1'b0, 4'($urandom), 4'h0, "exit_toggle");
      if (bus.is_exit_delay) cnt++;
    end
    chk("exit_len", 32'(cnt), 32'(EXIT));
    chk("armed", 32'(bus.is_armed), 32'd1);
    step(K_DIS, 1'b1, 4'h0, 4'h0, "disarm1");

    // Arm refused with a faulted zone, then accepted with that zone bypassed.
    step(K_ARM, 1'b1, 4'b0010, 4'h0, "refuse");
    chk("refuse_pulse", 32'(bus.arm_fail), 32'd1);
    chk("refuse_state", 32'(bus.state), 32'd0);
    step(4'h0, 1'b0, 4'b0010, 4'h0, "refuse_after");
    chk("refuse_one_clk", 32'(bus.arm_fail), 32'd0);
    step(K_ARM, 1'b1, 4'b0010, 4'b0010, "bypass_arm");
    chk("bypass_arm_exit", 32'(bus.is_exit_delay), 32'd1);
    for (int i = 0; i < EXIT; i++) step(4'h0, 1'b0, 4'b0010, 4'b0010, "bypass_exit");
    chk("bypass_armed", 32'(bus.is_armed), 32'd1);

    // Entry path: entry delay, siren, then silence.
    step(4'h0, 1'b0, 4'b0001, 4'h0, "entry_trip");
    cnt = 0;
    for (int i = 0; i < 20 && bus.is_entry_delay; i++) begin
      cnt++;
      step(4'h0, 1'b0, 4'h0, 4'h0, "entry_wait");
    end
    chk("entry_len", 32'(cnt), 32'(ENTRY));
    cnt = 0;
    for (int i = 0; i < 20 && bus.alarm_siren; i++) begin
      cnt++;
      step(4'h0, 1'b0, 4'h0, 4'h0, "siren_wait");
    end
    chk("siren_len", 32'(cnt), 32'(SIREN));
    chk("silenced", 32'(bus.state), 32'd5);
    chk("entry_trip_zones", 32'(bus.tripped_zones), 32'b0001);
    step(K_DIS, 1'b1, 4'h0, 4'h0, "disarm2");

    // Instant zone and retrigger from SILENCED.
    arm_now("rearm1");
    chk("rearm_clears_trip", 32'(bus.tripped_zones), 32'd0);
    step(4'h0, 1'b0, 4'b1000, 4'h0, "instant");
    chk("instant_siren", 32'(bus.alarm_siren), 32'd1);
    idle(SIREN, 4'h0, "instant_wait");
    chk("instant_silenced", 32'(bus.state), 32'd5);
    step(4'h0, 1'b0, 4'b0100, 4'h0, "retrig");
    cnt = 0;
    for (int i = 0; i < 20 && bus.alarm_siren; i++) begin
      cnt++;
      step(4'h0, 1'b0, 4'h0, 4'h0, "retrig_wait");
    end
    chk("retrig_len", 32'(cnt), 32'(SIREN));
    idle(3, 4'b1000, "no_retrig");
    chk("no_retrig_state", 32'(bus.state), 32'd5);
    step(K_DIS, 1'b1, 4'h0, 4'h0, "disarm3");

    // Disarm beats an instant trip in the same cycle; zones held until next arm.
    arm_now("rearm2");
    step(4'h0, 1'b0, 4'b0001, 4'h0, "prio_entry");
    step(K_DIS, 1'b1, 4'b1000, 4'h0, "prio_dis");
    chk("prio_state", 32'(bus.state), 32'd0);
    chk("prio_siren", 32'(bus.alarm_siren), 32'd0);
    idle(3, 4'h0, "prio_hold");
    chk("prio_trip_held", 32'(bus.tripped_zones), 32'b1001);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [3:0] kp, zin, byp;
      logic kv;
      r   = $urandom_range(0, 9);
      kp  = (r < 4) ? K_ARM : (r < 6) ? K_DIS : 4'($urandom);
      kv  = ($urandom_range(0, 4) == 0);
      zin = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      byp = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      step(kp, kv, zin, byp, "rand");
    end
    step(K_DIS, 1'b1, 4'h0, 4'h0, "disarm4");

    // Asynchronous reset in the middle of an alarm.
    arm_now("rearm3");
    step(4'h0, 1'b0, 4'b1000, 4'h0, "pre_reset_alarm");
    step(4'h0, 1'b0, 4'h0, 4'h0, "pre_reset_hold");
    chk("pre_reset_siren", 32'(bus.alarm_siren), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_siren", 32'(bus.alarm_siren), 32'd0);
    chk("async_state", 32'(bus.state), 32'd0);
    model_reset();
    check_all("async_reset");
    #10;
    reset_n = 1'b1;
    idle(2, 4'h0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
